contador_programable: RTL and testbench

Parametrised up/down modulo counter with runtime-programmable terminal value, synchronous load and three end-of-count modes (wrap, saturate, one-shot). It is the general-purpose counting element for timing and sequencing blocks: it drives a combinational terminal flag for cascading and a registered one-cycle wrap pulse. Optionally it keeps a count of completed wraps.

---
 rtl/contador_programable.sv | 106 ++++++++++
 tb/tb_contador_programable.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/contador_programable.sv
// Up/down modulo counter with programmable terminal value, synchronous load and
// wrap/saturate/one-shot end-of-count modes. Define CONTADOR_VUELTAS_EN to add the wrap counter.
module contador_programable #(
  parameter int unsigned MODULO        = 16,
  parameter int unsigned ANCHO_VUELTAS = 16,
  localparam int unsigned W            = (MODULO > 2) ? $clog2(MODULO) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     up_down,
  input  logic                     carga,
  input  logic [W-1:0]             entrada,
  input  logic [W-1:0]             limite,
  input  logic [1:0]               modo,
  output logic [W-1:0]             cuenta,
  output logic                     fin_cuenta,
  output logic                     desborde,
`ifdef CONTADOR_VUELTAS_EN
  output logic [ANCHO_VUELTAS-1:0] vueltas,
`endif
  output logic                     parado
);

  localparam logic [1:0] ModoWrap    = 2'b00;
  localparam logic [1:0] ModoSat     = 2'b01;
  localparam logic [1:0] ModoOneShot = 2'b10;

  if (MODULO < 2 || ANCHO_VUELTAS < 1) begin : g_param_check
    $error("contador_programable: MODULO must be >= 2 and ANCHO_VUELTAS >= 1");
  end

  logic [W-1:0] cuenta_q, cuenta_d;
  logic         desborde_q, desborde_d;
  logic         parado_q, parado_d;
  logic         fin;
  logic         evento;

  // Up counts to limite, down counts to zero; a count above limite (limite lowered) is terminal.
  assign fin = up_down ? (cuenta_q >= limite) : (cuenta_q == '0);

  always_comb begin
    cuenta_d   = cuenta_q;
    parado_d   = parado_q;
    desborde_d = 1'b0;
    evento     = 1'b0;
    if (carga) begin
      cuenta_d = (entrada > limite) ? limite : entrada;
      parado_d = 1'b0;
    end else if (enable && !parado_q) begin
      if (!fin) begin
        cuenta_d = up_down ? cuenta_q + W'(1) : cuenta_q - W'(1);
      end else begin
        unique case (modo)
          ModoSat: ;
          ModoOneShot: begin
            parado_d = 1'b1;
            evento   = 1'b1;
          end
          default: begin
            // ModoWrap and the reserved encoding both restart.
            cuenta_d = up_down ? '0 : limite;
            evento   = 1'b1;
          end
        endcase
      end
      desborde_d = evento;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cuenta_q   <= '0;
      desborde_q <= 1'b0;
      parado_q   <= 1'b0;
    end else begin
      cuenta_q   <= cuenta_d;
      desborde_q <= desborde_d;
      parado_q   <= parado_d;
    end
  end

`ifdef CONTADOR_VUELTAS_EN
  logic [ANCHO_VUELTAS-1:0] vueltas_q;

  // Not cleared by carga: only reset restarts the wrap tally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vueltas_q <= '0;
    end else if (evento) begin
      vueltas_q <= vueltas_q + ANCHO_VUELTAS'(1);
    end
  end

  assign vueltas = vueltas_q;
`endif

  assign cuenta     = cuenta_q;
  assign fin_cuenta = fin;
  assign desborde   = desborde_q;
  assign parado     = parado_q;

  logic unused_modo_ok;
  assign unused_modo_ok = (modo == ModoWrap);

endmodule

// File: tb/tb_contador_programable.sv
// Scoreboard bench for contador_programable (MODULO=16); vueltas checks need CONTADOR_VUELTAS_EN.
module tb_contador_programable;

  localparam int unsigned MODULO = 16;
  localparam int unsigned W      = 4;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         up_down;
  logic         carga;
  logic [W-1:0] entrada;
  logic [W-1:0] limite;
  logic [1:0]   modo;
  logic [W-1:0] cuenta;
  logic         fin_cuenta;
  logic         desborde;
  logic         parado;
`ifdef CONTADOR_VUELTAS_EN
  logic [15:0]  vueltas;
`endif

  contador_programable #(
    .MODULO       (MODULO),
    .ANCHO_VUELTAS(16)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .up_down   (up_down),
    .carga     (carga),
    .entrada   (entrada),
    .limite    (limite),
    .modo      (modo),
    .cuenta    (cuenta),
    .fin_cuenta(fin_cuenta),
    .desborde  (desborde),
`ifdef CONTADOR_VUELTAS_EN
    .vueltas   (vueltas),
`endif
    .parado    (parado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    cuenta;
    bit    desborde;
    bit    parado;
    bit    fin;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic en, input logic ud, input logic ca,
                      input logic [W-1:0] ent, input logic [W-1:0] lim, input logic [1:0] md,
                      input int exp_c, input bit exp_d, input bit exp_p);
    exp_t e;
    enable  = en;
    up_down = ud;
    carga   = ca;
    entrada = ent;
    limite  = lim;
    modo    = md;
    e.tag      = tag;
    e.cuenta   = exp_c;
    e.desborde = exp_d;
    e.parado   = exp_p;
    e.fin      = ud ? (exp_c >= int'(lim)) : (exp_c == 0);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_val({e.tag, "_cuenta"}, 32'(cuenta), 32'(e.cuenta));
    check_val({e.tag, "_desborde"}, 32'(desborde), 32'(e.desborde));
    check_val({e.tag, "_parado"}, 32'(parado), 32'(e.parado));
    check_val({e.tag, "_fin"}, 32'(fin_cuenta), 32'(e.fin));
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    up_down = 1'b1;
    carga   = 1'b0;
    entrada = '0;
    limite  = 4'd9;
    modo    = 2'b00;
    #12;
    reset = 1'b0;
    check_val("rst_cuenta", 32'(cuenta), 32'd0);
    check_val("rst_desborde", 32'(desborde), 32'd0);
    check_val("rst_parado", 32'(parado), 32'd0);
    check_val("rst_fin", 32'(fin_cuenta), 32'd0);
`ifdef CONTADOR_VUELTAS_EN
    check_val("rst_vueltas", 32'(vueltas), 32'd0);
`endif

    // Wrap up, limite 9: 1..9, 0 (with desborde), 1.
    for (int i = 1; i <= 11; i++) begin
      step("wrap_up", 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 2'b00, i % 10, i == 10, 1'b0);
    end
`ifdef CONTADOR_VUELTAS_EN
    check_val("wrap_up_vueltas", 32'(vueltas), 32'd1);
`endif

    // Wrap down, limite 5, load 2: 2,1,0,5(desborde),4.
    step("down_load", 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 2'b00, 2, 1'b0, 1'b0);
    step("down_1", 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 2'b00, 1, 1'b0, 1'b0);
    step("down_0", 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 2'b00, 0, 1'b0, 1'b0);
    step("down_wrap", 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 2'b00, 5, 1'b1, 1'b0);
    step("down_4", 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 2'b00, 4, 1'b0, 1'b0);
`ifdef CONTADOR_VUELTAS_EN
    check_val("down_vueltas", 32'(vueltas), 32'd2);
`endif

    // Saturate, limite 15, load 13: 13,14,15,15,15 without desborde.
    step("sat_load", 1'b0, 1'b1, 1'b1, 4'd13, 4'd15, 2'b01, 13, 1'b0, 1'b0);
    step("sat_14", 1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 2'b01, 14, 1'b0, 1'b0);
    step("sat_15", 1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 2'b01, 15, 1'b0, 1'b0);
    step("sat_hold_a", 1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 2'b01, 15, 1'b0, 1'b0);
    step("sat_hold_b", 1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 2'b01, 15, 1'b0, 1'b0);

    // One-shot, limite 3 from 0: stops at 3 with a single desborde, then reload to 1.
    step("os_load", 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 2'b10, 0, 1'b0, 1'b0);
    step("os_1", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 2'b10, 1, 1'b0, 1'b0);
    step("os_2", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 2'b10, 2, 1'b0, 1'b0);
    step("os_3", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 2'b10, 3, 1'b0, 1'b0);
    step("os_stop", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 2'b10, 3, 1'b1, 1'b1);
    step("os_frozen_a", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 2'b10, 3, 1'b0, 1'b1);
    step("os_frozen_b", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 2'b10, 3, 1'b0, 1'b1);
    step("os_reload", 1'b0, 1'b1, 1'b1, 4'd1, 4'd3, 2'b10, 1, 1'b0, 1'b0);
`ifdef CONTADOR_VUELTAS_EN
    check_val("os_vueltas", 32'(vueltas), 32'd3);
`endif

    // Wrap at limite 1 to raise desborde, then carga+enable with clamp 12 -> 7.
    step("pri_wrap", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 2'b00, 0, 1'b1, 1'b0);
    step("pri_clamp", 1'b1, 1'b1, 1'b1, 4'd12, 4'd7, 2'b00, 7, 1'b0, 1'b0);
    step("limite0_a", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00, 0, 1'b0, 1'b0);
    step("limite0_b", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 0, 1'b1, 1'b0);
    step("limite0_c", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b11, 0, 1'b1, 1'b0);
`ifdef CONTADOR_VUELTAS_EN
    check_val("pri_vueltas", 32'(vueltas), 32'd6);
`endif

    // One-shot stop at 6, then async reset between edges.
    step("ar_load", 1'b0, 1'b1, 1'b1, 4'd5, 4'd6, 2'b10, 5, 1'b0, 1'b0);
    step("ar_6", 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 2'b10, 6, 1'b0, 1'b0);
    step("ar_stop", 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 2'b10, 6, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("ar_cuenta", 32'(cuenta), 32'd0);
    check_val("ar_desborde", 32'(desborde), 32'd0);
    check_val("ar_parado", 32'(parado), 32'd0);
`ifdef CONTADOR_VUELTAS_EN
    check_val("ar_vueltas", 32'(vueltas), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
